// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl
//  Description : Pipeline stall/flush controller with a mult/div occupancy FSM.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_md_use,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_read,
    input  logic                  ex_md_start,
    input  logic                  ex_md_is_div,
    input  logic                  ex_branch_taken,
    input  logic                  imem_stall,
    input  logic                  dmem_stall,
    input  logic                  exc_flush,
    output logic                  stall_pc,
    output logic                  stall_if_id,
    output logic                  stall_id_ex,
    output logic                  stall_ex_mem,
    output logic                  flush_if_id,
    output logic                  flush_id_ex,
    output logic                  flush_ex_mem,
    output logic                  md_busy,
    output logic                  md_done
);

    localparam logic [1:0]       c_st_idle  = 2'd0;
    localparam logic [1:0]       c_st_run   = 2'd1;
    localparam logic [1:0]       c_st_done  = 2'd2;

    localparam logic [CNT_W-1:0] c_mul_load = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_div_load = CNT_W'(DIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_cnt_zero = '0;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;

    logic [CNT_W-1:0] w_load;
    logic             w_lu_haz;
    logic             w_md_haz;

    assign w_load = ex_md_is_div ? c_div_load : c_mul_load;

    // The counter deliberately ignores dmem_stall: the unit keeps computing
    // while the memory stage waits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_idle;
            r_cnt   <= c_cnt_zero;
        end else if (exc_flush) begin
            r_state <= c_st_idle;
            r_cnt   <= c_cnt_zero;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (ex_md_start) begin
                        r_state <= c_st_run;
                        r_cnt   <= w_load;
                    end
                end
                c_st_run: begin
                    if (r_cnt != c_cnt_zero) begin
                        r_cnt <= r_cnt - c_cnt_one;
                    end else begin
                        r_state <= c_st_done;
                    end
                end
                c_st_done: begin
                    if (ex_md_start) begin
                        r_state <= c_st_run;
                        r_cnt   <= w_load;
                    end else begin
                        r_state <= c_st_idle;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                    r_cnt   <= c_cnt_zero;
                end
            endcase
        end
    end

    assign w_lu_haz = ex_mem_read && (ex_rd != '0) &&
                      ((ex_rd == id_rs) || (ex_rd == id_rt));

    // A start seen in EX already occupies the unit for the ID instruction.
    assign w_md_haz = id_md_use &&
                      ((r_state == c_st_run) || ((r_state == c_st_idle) && ex_md_start));

    always_comb begin
        stall_pc     = 1'b0;
        stall_if_id  = 1'b0;
        stall_id_ex  = 1'b0;
        stall_ex_mem = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        flush_ex_mem = 1'b0;
        if (!rst) begin
            if (exc_flush) begin
                flush_if_id  = 1'b1;
                flush_id_ex  = 1'b1;
                flush_ex_mem = 1'b1;
            end else if (dmem_stall) begin
                stall_pc     = 1'b1;
                stall_if_id  = 1'b1;
                stall_id_ex  = 1'b1;
                stall_ex_mem = 1'b1;
            end else if (ex_branch_taken) begin
                // PC must load the redirect target even if fetch is stalled.
                flush_if_id  = 1'b1;
                flush_id_ex  = 1'b1;
            end else if (w_lu_haz || w_md_haz) begin
                stall_pc     = 1'b1;
                stall_if_id  = 1'b1;
                flush_id_ex  = 1'b1;
            end else if (imem_stall) begin
                stall_pc     = 1'b1;
                flush_if_id  = 1'b1;
            end
        end
    end

    assign md_busy = !rst && (r_state == c_st_run);
    assign md_done = !rst && (r_state == c_st_done);

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_ctrl
//  Description : Directed and random bench for hazard_ctrl with a cycle model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

    localparam int c_mul = 4;
    localparam int c_div = 32;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs, id_rt, ex_rd;
    logic       id_md_use, ex_mem_read, ex_md_start, ex_md_is_div;
    logic       ex_branch_taken, imem_stall, dmem_stall, exc_flush;
    logic       stall_pc, stall_if_id, stall_id_ex, stall_ex_mem;
    logic       flush_if_id, flush_id_ex, flush_ex_mem, md_busy, md_done;

    int n_pass  = 0;
    int n_total = 0;

    // Model of the unit: cycles of occupancy left, and a pending result pulse.
    int m_left = 0;
    bit m_done = 0;

    int busy_seen, stall_seen;

    always #5 clk = ~clk;

    hazard_ctrl #(
        .REG_ADDR_W(5), .MUL_CYCLES(c_mul), .DIV_CYCLES(c_div), .CNT_W(6)
    ) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_md_use(id_md_use),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .ex_md_start(ex_md_start), .ex_md_is_div(ex_md_is_div),
        .ex_branch_taken(ex_branch_taken), .imem_stall(imem_stall),
        .dmem_stall(dmem_stall), .exc_flush(exc_flush),
        .stall_pc(stall_pc), .stall_if_id(stall_if_id),
        .stall_id_ex(stall_id_ex), .stall_ex_mem(stall_ex_mem),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
        .flush_ex_mem(flush_ex_mem), .md_busy(md_busy), .md_done(md_done)
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs == exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic idle_inputs();
        rst = 0; id_rs = 0; id_rt = 0; ex_rd = 0; id_md_use = 0;
        ex_mem_read = 0; ex_md_start = 0; ex_md_is_div = 0;
        ex_branch_taken = 0; imem_stall = 0; dmem_stall = 0; exc_flush = 0;
    endtask

    // Expected outputs {stall pc,ifid,idex,exmem, flush ifid,idex,exmem, busy, done}
    function automatic logic [8:0] expect_out();
        bit idle, lu, md;
        logic [8:0] e;
        if (rst) return 9'b0;
        idle = (m_left == 0) && !m_done;
        lu   = ex_mem_read && (ex_rd != 0) && (ex_rd == id_rs || ex_rd == id_rt);
        md   = id_md_use && (m_left > 0 || (idle && ex_md_start));
        e    = 9'b0;
        e[1] = (m_left > 0);
        e[0] = m_done;
        if (exc_flush)            e[4:2] = 3'b111;
        else if (dmem_stall)      e[8:5] = 4'b1111;
        else if (ex_branch_taken) e[4:3] = 2'b11;
        else if (lu || md)        begin e[8:7] = 2'b11; e[3] = 1'b1; end
        else if (imem_stall)      begin e[8] = 1'b1; e[4] = 1'b1; end
        return e;
    endfunction

    task automatic check_all(input string tag);
        logic [8:0] e;
        e = expect_out();
        chk({tag, ".stall_pc"},     stall_pc,     e[8]);
        chk({tag, ".stall_if_id"},  stall_if_id,  e[7]);
        chk({tag, ".stall_id_ex"},  stall_id_ex,  e[6]);
        chk({tag, ".stall_ex_mem"}, stall_ex_mem, e[5]);
        chk({tag, ".flush_if_id"},  flush_if_id,  e[4]);
        chk({tag, ".flush_id_ex"},  flush_id_ex,  e[3]);
        chk({tag, ".flush_ex_mem"}, flush_ex_mem, e[2]);
        chk({tag, ".md_busy"},      md_busy,      e[1]);
        chk({tag, ".md_done"},      md_done,      e[0]);
    endtask

    task automatic model_clock();
        if (rst || exc_flush) begin
            m_left = 0; m_done = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) m_done = 1;
        end else begin
            m_done = 0;
            if (ex_md_start) m_left = ex_md_is_div ? c_div : c_mul;
        end
    endtask

    // Inputs are applied at the falling edge; outputs sampled 1 ns later.
    task automatic step(input string tag);
        if (rst) begin m_left = 0; m_done = 0; end
        #1;
        check_all(tag);
        busy_seen  += int'(md_busy);
        stall_seen += int'(stall_if_id);
        @(posedge clk);
        model_clock();
        @(negedge clk);
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        imem_stall = 1; ex_branch_taken = 1;
        @(negedge clk);
        step("reset");
        idle_inputs();
        step("post_reset");

        ex_mem_read = 1; ex_rd = 5; id_rt = 5;
        step("loaduse");
        ex_rd = 0; id_rt = 0;
        step("loaduse_r0");
        idle_inputs();

        busy_seen = 0; stall_seen = 0;
        ex_md_start = 1; ex_md_is_div = 1; id_md_use = 1;
        step("div_start");
        ex_md_start = 0;
        repeat (c_div + 1) step("div_run");
        chk_int("div_busy_cycles", busy_seen, c_div);
        chk_int("div_stall_cycles", stall_seen, c_div + 1);
        idle_inputs();
        step("div_idle");

        busy_seen = 0;
        ex_md_start = 1;
        step("mul_start");
        ex_md_start = 0;
        repeat (c_mul) step("mul_run");
        ex_md_start = 1;
        step("mul_done_restart");
        ex_md_start = 0;
        repeat (c_mul + 1) step("mul_run2");
        chk_int("mul_b2b_busy_cycles", busy_seen, 2 * c_mul);

        dmem_stall = 1; ex_branch_taken = 1;
        repeat (3) step("dmem_branch");
        dmem_stall = 0;
        step("branch_release");
        idle_inputs();

        ex_md_start = 1; ex_md_is_div = 1;
        step("exc_div_start");
        ex_md_start = 0;
        repeat (5) step("exc_div_run");
        exc_flush = 1; dmem_stall = 1; ex_mem_read = 1; ex_rd = 7; id_rs = 7;
        id_md_use = 1;
        step("exc_all");
        idle_inputs();
        repeat (2) step("exc_after");

        // Asynchronous reset mid-divide, released before any clock edge.
        ex_md_start = 1; ex_md_is_div = 1;
        step("rst_div_start");
        ex_md_start = 0;
        repeat (14) step("rst_div_run");
        rst = 1; imem_stall = 1;
        #1;
        check_all("rst_async");
        #1;
        rst = 0; m_left = 0; m_done = 0;
        step("rst_async_after");
        idle_inputs();
        repeat (c_div + 2) step("rst_no_done");

        for (int i = 0; i < 3000; i++) begin
            rst             = ($urandom_range(0, 199) == 0);
            id_rs           = 5'($urandom_range(0, 3));
            id_rt           = 5'($urandom_range(0, 3));
            ex_rd           = 5'($urandom_range(0, 3));
            id_md_use       = ($urandom_range(0, 9) < 4);
            ex_mem_read     = ($urandom_range(0, 9) < 3);
            ex_md_start     = ($urandom_range(0, 9) < 2);
            ex_md_is_div    = ($urandom_range(0, 9) < 3);
            ex_branch_taken = ($urandom_range(0, 9) == 0);
            imem_stall      = ($urandom_range(0, 9) < 2);
            dmem_stall      = ($urandom_range(0, 99) < 15);
            exc_flush       = ($urandom_range(0, 99) < 3);
            step("random");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
